// File: rtl/regfile_phased.sv
// regfile_phased: phase-sequenced 32x32 register file with a registered read phase and a qualified write-back phase
module regfile_phased #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_PHASES  = 10,
    parameter int READ_PHASE  = 3,
    parameter int WRITE_PHASE = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  regWrite,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [3:0]            phase
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [3:0]            r_cont;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [DATA_WIDTH-1:0] r_rdata2;
    logic [3:0]            w_cont_next;
    logic                  w_read_en;
    logic                  w_write_en;
    logic [DATA_WIDTH-1:0] w_rdata1;
    logic [DATA_WIDTH-1:0] w_rdata2;

    // Next phase, the sample/commit strobes and the x0-masked read operands
    always_comb begin
        w_cont_next = (r_cont == 4'(NUM_PHASES - 1)) ? 4'd0 : r_cont + 4'd1;
        w_read_en   = (r_cont == 4'(READ_PHASE));
        w_write_en  = (r_cont == 4'(WRITE_PHASE)) && regWrite && (rd != '0);
        w_rdata1    = (rs1 == '0) ? '0 : r_regs[rs1];
        w_rdata2    = (rs2 == '0) ? '0 : r_regs[rs2];
    end

    // Free-running phase counter shared in lockstep with the rest of the datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_cont <= 4'd0;
        else        r_cont <= w_cont_next;
    end

    // Register array in flops so the async reset clears every entry; x0 is never written
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)          r_regs <= '{default: '0};
        else if (w_write_en) r_regs[rd] <= writeData;
    end

    // Operand latches: sampled only in the read phase, held for the rest of the instruction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else if (w_read_en) begin
            r_rdata1 <= w_rdata1;
            r_rdata2 <= w_rdata2;
        end
    end

    assign readData1 = r_rdata1;
    assign readData2 = r_rdata2;
    assign phase     = r_cont;
endmodule

// File: tb/tb_regfile_phased.sv
// tb_regfile_phased: table-driven and randomized checks of regfile_phased against a per-edge reference model
module tb_regfile_phased;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        regWrite = 1'b0;
    logic [31:0] writeData = '0;
    logic [31:0] readData1, readData2;
    logic [3:0]  phase;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_reg [32];
    int          m_phase = 0;
    logic [31:0] m_r1 = '0, m_r2 = '0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;
    vec_t tbl [7];

    regfile_phased dut (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .regWrite(regWrite), .writeData(writeData),
        .readData1(readData1), .readData2(readData2), .phase(phase)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_phase = 0;
        m_r1 = '0;
        m_r2 = '0;
    endtask

    // One clock: model follows the rules on the edge, DUT compared on the falling edge
    task automatic cyc();
        @(posedge clock);
        if (reset) begin
            if (m_phase == 3) begin
                m_r1 = m_reg[rs1];
                m_r2 = m_reg[rs2];
            end
            if (m_phase == 9 && regWrite && rd != 0) m_reg[rd] = writeData;
            m_phase = (m_phase + 1) % 10;
        end
        @(negedge clock);
        check("phase", 32'(phase), 32'(m_phase));
        check("readData1", readData1, m_r1);
        check("readData2", readData2, m_r2);
    endtask

    // One instruction of 10 edges: operands valid only at the read phase and write fields only at the write phase; noise elsewhere
    task automatic instr(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                         input logic we, input logic [31:0] wd);
        for (int p = 0; p < 10; p++) begin
            rs1 = (m_phase == 3) ? a1 : 5'($urandom);
            rs2 = (m_phase == 3) ? a2 : 5'($urandom);
            if (m_phase == 9) begin
                regWrite = we;
                rd = ad;
                writeData = wd;
            end else begin
                regWrite = 1'($urandom);
                rd = 5'($urandom_range(1, 31));
                writeData = $urandom;
            end
            cyc();
        end
    endtask

    initial begin
        tbl[0] = '{5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0};
        tbl[1] = '{5'd5, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{5'd0, 5'd5, 5'd3, 1'b1, 32'h00000011, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{5'd5, 5'd3, 5'd3, 1'b1, 32'h00000022, 32'hDEADBEEF, 32'h11};
        tbl[4] = '{5'd3, 5'd3, 5'd7, 1'b0, 32'h12345678, 32'h22, 32'h22};
        tbl[5] = '{5'd7, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0};
        tbl[6] = '{5'd5, 5'd3, 5'd0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h22};
        model_clear();
        repeat (2) @(negedge clock);
        check("reset_phase", 32'(phase), 32'h0);
        check("reset_rd1", readData1, 32'h0);
        check("reset_rd2", readData2, 32'h0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            instr(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].wd);
            check($sformatf("tbl%0d_rd1", i), readData1, tbl[i].e1);
            check($sformatf("tbl%0d_rd2", i), readData2, tbl[i].e2);
        end

        regWrite = 1'b0;
        repeat (5) cyc();
        check("pre_reset_phase", 32'(phase), 32'd5);
        #2 reset = 1'b0;
        #1;
        model_clear();
        check("async_phase", 32'(phase), 32'h0);
        check("async_rd1", readData1, 32'h0);
        check("async_rd2", readData2, 32'h0);
        regWrite = 1'b1;
        rd = 5'd9;
        writeData = 32'hCAFEF00D;
        rs1 = 5'd5;
        rs2 = 5'd3;
        @(negedge clock);
        repeat (3) cyc();
        regWrite = 1'b0;
        reset = 1'b1;
        repeat (3) cyc();
        check("release_phase3", 32'(phase), 32'd3);
        cyc();
        check("release_rd1", readData1, 32'h0);
        check("release_rd2", readData2, 32'h0);
        repeat (6) cyc();

        for (int i = 1; i < 32; i++) instr(5'($urandom), 5'($urandom), 5'(i), 1'b1, 32'(i) * 32'h01010101);
        for (int i = 1; i < 32; i++) begin
            instr(5'(i), 5'(32 - i), 5'd0, 1'b0, 32'h0);
            check("sweep_rd1", readData1, 32'(i) * 32'h01010101);
            check("sweep_rd2", readData2, 32'(32 - i) * 32'h01010101);
            check("sweep_wrap", 32'(phase), 32'h0);
        end

        for (int n = 0; n < 200; n++)
            instr(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
